// File: rtl/mhd_seq_checker.sv
// ----------------------------------------------------------------------------
// mhd_seq_checker
//
// Sequential Hamming-distance checker. One operand pair (a, b) is accepted in
// IDLE, the difference vector a^b is latched and popcounted CHUNK bits per
// cycle by a single shared adder, and the resulting distance is presented
// together with a violation flag (distance > MHD) until the consumer takes it.
// Running statistics (results delivered, violations delivered, largest
// distance seen) are updated on every output handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  checker idle and able to accept a pair
//   in_a       in   operand a  [WIDTH]
//   in_b       in   operand b  [WIDTH]
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts the result
//   out_dist   out  Hamming distance of the pair [DW]
//   out_viol   out  out_dist > MHD
//   clear      in   synchronous clear of the statistics
//   viol_cnt   out  violating results delivered, saturating [16]
//   pair_cnt   out  results delivered, saturating [16]
//   max_dist   out  largest distance delivered since reset/clear [DW]
// ----------------------------------------------------------------------------
module mhd_seq_checker #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned MHD   = 6,
    parameter int unsigned CHUNK = 6,
    localparam int unsigned DW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_dist,
    output logic             out_viol,
    input  logic             clear,
    output logic [15:0]      viol_cnt,
    output logic [15:0]      pair_cnt,
    output logic [DW-1:0]    max_dist
);

    localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    // Difference register is padded up to a whole number of slices so the last
    // slice reads zeros above WIDTH.
    localparam int unsigned PADW   = NCHUNK * CHUNK;
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CW     = $clog2(CHUNK + 1);
    localparam logic [IW-1:0] LastIdx = IW'(NCHUNK - 1);
    localparam logic [15:0]   CntMax  = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [PADW-1:0]   diff_q, diff_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [15:0]       viol_cnt_q, viol_cnt_d;
    logic [15:0]       pair_cnt_q, pair_cnt_d;
    logic [DW-1:0]     max_dist_q, max_dist_d;

    logic [CHUNK-1:0]  slice;
    logic [CW-1:0]     slice_cnt;
    logic              viol;
    logic              out_hs;

    // ------------------------------------------------------------------------
    // Shared slice popcount
    // ------------------------------------------------------------------------
    assign slice = diff_q[idx_q * CHUNK +: CHUNK];

    always_comb begin
        slice_cnt = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            slice_cnt = slice_cnt + CW'(slice[i]);
        end
    end

    // Compared at 32 bits so that MHD >= WIDTH can never flag a violation.
    assign viol = (32'(acc_q) > MHD);

    // ------------------------------------------------------------------------
    // Control FSM: next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        diff_d    = diff_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    diff_d  = PADW'(in_a ^ in_b);
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                acc_d = acc_q + DW'(slice_cnt);
                idx_d = idx_q + IW'(1);
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign out_dist = acc_q;
    assign out_viol = viol;
    assign out_hs   = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Statistics; clear takes priority over a coincident handshake
    // ------------------------------------------------------------------------
    always_comb begin
        viol_cnt_d = viol_cnt_q;
        pair_cnt_d = pair_cnt_q;
        max_dist_d = max_dist_q;
        if (clear) begin
            viol_cnt_d = '0;
            pair_cnt_d = '0;
            max_dist_d = '0;
        end else if (out_hs) begin
            if (pair_cnt_q != CntMax) begin
                pair_cnt_d = pair_cnt_q + 16'd1;
            end
            if (viol && (viol_cnt_q != CntMax)) begin
                viol_cnt_d = viol_cnt_q + 16'd1;
            end
            if (acc_q > max_dist_q) begin
                max_dist_d = acc_q;
            end
        end
    end

    assign viol_cnt = viol_cnt_q;
    assign pair_cnt = pair_cnt_q;
    assign max_dist = max_dist_q;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            diff_q     <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            viol_cnt_q <= '0;
            pair_cnt_q <= '0;
            max_dist_q <= '0;
        end else begin
            state_q    <= state_d;
            diff_q     <= diff_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            viol_cnt_q <= viol_cnt_d;
            pair_cnt_q <= pair_cnt_d;
            max_dist_q <= max_dist_d;
        end
    end

endmodule

// File: tb/tb_mhd_seq_checker.sv
// ----------------------------------------------------------------------------
// tb_mhd_seq_checker
//
// Directed and randomized checks of mhd_seq_checker against a reference model
// built from $countones and plain saturating counters. A second instance with
// WIDTH=17 exercises the padded last slice.
// ----------------------------------------------------------------------------
module tb_mhd_seq_checker;

    localparam int NCH = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_dist;
    logic        out_viol;
    logic        clear;
    logic [15:0] viol_cnt;
    logic [15:0] pair_cnt;
    logic [4:0]  max_dist;

    logic        iv17;
    logic        ir17;
    logic [16:0] a17;
    logic [16:0] b17;
    logic        ov17;
    logic        or17;
    logic [4:0]  d17;
    logic        viol17;
    logic        clr17;
    logic [15:0] vc17;
    logic [15:0] pc17;
    logic [4:0]  md17;

    int n_vec;
    int n_err;
    int m_pair;
    int m_viol;
    int m_max;

    mhd_seq_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dist  (out_dist),
        .out_viol  (out_viol),
        .clear     (clear),
        .viol_cnt  (viol_cnt),
        .pair_cnt  (pair_cnt),
        .max_dist  (max_dist)
    );

    mhd_seq_checker #(.WIDTH(17), .MHD(6), .CHUNK(6)) dut17 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv17),
        .in_ready  (ir17),
        .in_a      (a17),
        .in_b      (b17),
        .out_valid (ov17),
        .out_ready (or17),
        .out_dist  (d17),
        .out_viol  (viol17),
        .clear     (clr17),
        .viol_cnt  (vc17),
        .pair_cnt  (pc17),
        .max_dist  (md17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_pair_cnt"}, 32'(pair_cnt), 32'(m_pair));
        check({tag, "_viol_cnt"}, 32'(viol_cnt), 32'(m_viol));
        check({tag, "_max_dist"}, 32'(max_dist), 32'(m_max));
    endtask

    // One full transaction on the default instance: accept, scan, hold the
    // result for 'hold' cycles (optionally with noise on the input side), then
    // hand it off with 'clr' asserted alongside the handshake if requested.
    task automatic run_pair(input logic [17:0] a, input logic [17:0] b, input int hold,
                            input bit clr, input bit noisy, input string tag);
        int  k;
        int  exp_d;
        bit  exp_v;
        exp_d = $countones(a ^ b);
        exp_v = (exp_d > 6);
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        in_a     = 18'($urandom);
        in_b     = 18'($urandom);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(NCH));
        check({tag, "_dist"}, 32'(out_dist), 32'(exp_d));
        check({tag, "_viol"}, 32'(out_viol), 32'(exp_v));
        for (int i = 0; i < hold; i++) begin
            if (noisy) begin
                in_valid = 1'b1;
                in_a     = 18'($urandom);
                in_b     = 18'($urandom);
            end
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_dist"}, 32'(out_dist), 32'(exp_d));
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        clear     = clr;
        tick();
        out_ready = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        if (clr) begin
            m_pair = 0;
            m_viol = 0;
            m_max  = 0;
        end else begin
            m_pair = (m_pair == 65535) ? 65535 : m_pair + 1;
            if (exp_v) m_viol = (m_viol == 65535) ? 65535 : m_viol + 1;
            if (exp_d > m_max) m_max = exp_d;
        end
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_stats(tag);
    endtask

    initial begin
        int k;
        int seen;
        logic [17:0] ra;
        logic [17:0] rm;

        n_vec = 0;
        n_err = 0;
        m_pair = 0;
        m_viol = 0;
        m_max  = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        clear = 1'b0;
        iv17 = 1'b0;
        a17 = '0;
        b17 = '0;
        or17 = 1'b0;
        clr17 = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_dist", 32'(out_dist), 32'd0);
        check("rst_out_viol", 32'(out_viol), 32'd0);
        check_stats("rst");
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Distance exactly MHD is not a violation
        run_pair(18'h00000, 18'h0003F, 0, 1'b0, 1'b0, "eq_mhd");
        // All ones, then identical operands
        run_pair(18'h3FFFF, 18'h00000, 0, 1'b0, 1'b0, "all_ones");
        run_pair(18'h2AAAA, 18'h2AAAA, 0, 1'b0, 1'b0, "equal");
        check("two_pairs_viol", 32'(viol_cnt), 32'd1);
        check("two_pairs_max", 32'(max_dist), 32'd18);

        // Backpressure with noise on the input side
        run_pair(18'h155A3, 18'h00F0F, 10, 1'b0, 1'b1, "bp");
        run_pair(18'h00001, 18'h00000, 0, 1'b0, 1'b0, "after_bp");

        // Reset in the second scan cycle discards the pair
        in_valid = 1'b1;
        in_a = 18'h3FFFF;
        in_b = 18'h00000;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pair = 0;
        m_viol = 0;
        m_max  = 0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_dist", 32'(out_dist), 32'd0);
        check_stats("midrst");
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_ghost", 32'(seen), 32'd0);

        // Clear coincident with a violating handshake wins
        run_pair(18'h00001, 18'h00000, 0, 1'b0, 1'b0, "pre_clr");
        run_pair(18'h3FFFF, 18'h00000, 2, 1'b1, 1'b0, "clr_hs");
        run_pair(18'h00000, 18'h0007F, 0, 1'b0, 1'b0, "dist7");

        // Clear while idle
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_pair = 0;
        m_viol = 0;
        m_max  = 0;
        check_stats("idle_clr");

        // Randomized pairs: dense and sparse differences around the threshold
        for (int t = 0; t < 40; t++) begin
            ra = 18'($urandom);
            if ($urandom_range(0, 1) == 0) rm = 18'($urandom);
            else rm = 18'($urandom & $urandom & $urandom);
            run_pair(ra, ra ^ rm, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 1) == 1), "rnd");
        end

        // Counter saturation
        force dut.pair_cnt_q = 16'hFFFF;
        force dut.viol_cnt_q = 16'hFFFF;
        #1;
        release dut.pair_cnt_q;
        release dut.viol_cnt_q;
        m_pair = 65535;
        m_viol = 65535;
        check("sat_preset", 32'(pair_cnt), 32'h0000FFFF);
        run_pair(18'h3FFFF, 18'h00001, 0, 1'b0, 1'b0, "sat");

        // WIDTH=17: padded bit of the last slice contributes nothing
        k = 0;
        while (!ir17 && k < 50) begin
            tick();
            k++;
        end
        check("w17_ready", 32'(ir17), 32'd1);
        iv17 = 1'b1;
        a17 = 17'h1FFFF;
        b17 = 17'h00000;
        tick();
        iv17 = 1'b0;
        k = 0;
        while (!ov17 && k < 20) begin
            tick();
            k++;
        end
        check("w17_latency", 32'(k), 32'(NCH));
        check("w17_dist", 32'(d17), 32'd17);
        check("w17_viol", 32'(viol17), 32'd1);
        or17 = 1'b1;
        tick();
        or17 = 1'b0;
        check("w17_pair_cnt", 32'(pc17), 32'd1);
        check("w17_max_dist", 32'(md17), 32'd17);
        check("w17_ready_back", 32'(ir17), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
